// File: rtl/comparador_serial_n_if.sv
`default_nettype none
// ============================================================================
// Module      : comparador_serial_n_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               serial magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
interface comparador_serial_n_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int NCHK = WIDTH / CHUNK;
  localparam int NW   = $clog2(NCHK) + 1;

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             G;
  logic             L;
  logic             E;
  logic [NW-1:0]    nchk;

  // Requester side: issues operands and start, observes results.
  modport master (
    output start, signed_mode, A, B,
    input  busy, done, G, L, E, nchk
  );

  // Comparator side.
  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, G, L, E, nchk
  );
endinterface
`default_nettype wire

// File: rtl/comparador_serial_n.sv
`default_nettype none
// ============================================================================
// Module      : comparador_serial_n
// Description : Multi-cycle WIDTH-bit magnitude comparator. Operands are
//               latched on start and scanned CHUNK bits per clock, MS chunk
//               first, stopping at the first unequal chunk. Supports
//               unsigned and two's-complement compare.
// Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  comparador_serial_n_if.slave bus
);

  localparam int NCHK = WIDTH / CHUNK;
  localparam int NW   = $clog2(NCHK) + 1;

  localparam logic [NW-1:0] c_LAST = NW'(NCHK - 1);
  localparam logic [NW-1:0] c_NCHK = NW'(NCHK);

  // Reject operand widths that do not split into whole chunks.
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("comparador_serial_n: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [NW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_g;
  logic             r_l;
  logic             r_e;
  logic [NW-1:0]    r_nchk;

  // The operand registers shift left after every equal chunk, so the chunk
  // under test is always the top CHUNK bits; r_idx only tracks position.
  logic             w_top;
  logic [CHUNK-1:0] w_msk;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_gt;
  logic             w_lt;
  logic [NW-1:0]    w_nchk_now;

  assign w_top      = (r_idx == c_LAST);
  // Flipping the sign bit of the top chunk turns a two's-complement order
  // into an unsigned order for that chunk.
  assign w_msk      = CHUNK'(r_sgn & w_top) << (CHUNK - 1);
  assign w_ca       = r_a[WIDTH-1 -: CHUNK] ^ w_msk;
  assign w_cb       = r_b[WIDTH-1 -: CHUNK] ^ w_msk;
  assign w_gt       = (w_ca > w_cb);
  assign w_lt       = (w_ca < w_cb);
  assign w_nchk_now = c_NCHK - r_idx;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_nchk  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_sgn   <= bus.signed_mode;
            r_idx   <= c_LAST;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
            r_nchk  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_gt || w_lt) begin
            r_g     <= w_gt;
            r_l     <= w_lt;
            r_nchk  <= w_nchk_now;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            r_e     <= 1'b1;
            r_nchk  <= c_NCHK;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
            r_idx <= r_idx - NW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.G    = r_g;
  assign bus.L    = r_l;
  assign bus.E    = r_e;
  assign bus.nchk = r_nchk;

endmodule
`default_nettype wire
